// File: rtl/weight_loader_param_if.sv
// SRAM read port bundle for weight_loader_param: the loader drives the
// read enable and address, and the SRAM returns data RD_LAT cycles later.
interface weight_loader_param_if #(
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W     = 16
);
  logic                    sram_re;
  logic [ADDR_W-1:0]       sram_addr;
  logic [WORD_BYTES*8-1:0] sram_rdata;

  modport master (output sram_re, output sram_addr, input sram_rdata);
  modport slave  (input sram_re, input sram_addr, output sram_rdata);
endinterface

// File: rtl/weight_loader_param.sv
// Parametrised conv-layer weight loader: streams NUM_FILT*CH*K*K bytes from SRAM into
// local registers and presents one filter's kernel row-packed. Optional macro: WLOAD_CHECKSUM_EN.
module weight_loader_param #(
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W     = 16,
  parameter int K          = 3,
  parameter int CH         = 4,
  parameter int NUM_FILT   = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            cfg_base_addr,
  input  logic [15:0]                  cfg_checksum,
  weight_loader_param_if.master        sram,
  input  logic [$clog2(NUM_FILT):0]    filt_sel,
  output logic [K*K*CH*8-1:0]          kernel_o,
  output logic                         busy,
  output logic                         done,
  output logic                         chk_err
);

  localparam int TOT        = NUM_FILT * CH * K * K;
  localparam int NWORDS     = (TOT + WORD_BYTES - 1) / WORD_BYTES;
  localparam int LAST_BYTES = TOT - (NWORDS - 1) * WORD_BYTES;
  localparam int CNT_W      = $clog2(NWORDS + 1);
  localparam int KB         = K * K * CH;
  localparam int FS_W       = $clog2(NUM_FILT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_sramRe;
  logic [ADDR_W-1:0]   r_sramAddr;
  logic [CNT_W-1:0]    r_issueCnt;
  logic [CNT_W-1:0]    r_capCnt;
  logic [RD_LAT-1:0]   r_vld;
  logic [7:0]          r_wgt [TOT];
  logic [KB*8-1:0]     w_kernel;
  logic                w_accept;
  logic                w_lastIssue;
  logic                w_capture;
  logic                w_doneRise;

  assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_lastIssue = (r_issueCnt == CNT_W'(NWORDS));
  assign w_capture   = r_vld[RD_LAT-1];
  assign w_doneRise  = (r_state == S_DRAIN) && (r_capCnt == CNT_W'(NWORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_FETCH;
      S_FETCH:        if (w_lastIssue) w_next = S_DRAIN;
      S_DRAIN:        if (w_doneRise) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  // Issue side: word 0 goes out on the accepting edge, then one word per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sramRe   <= 1'b0;
      r_sramAddr <= '0;
      r_issueCnt <= '0;
    end else if (w_accept) begin
      r_sramRe   <= 1'b1;
      r_sramAddr <= cfg_base_addr;
      r_issueCnt <= CNT_W'(1);
    end else if (r_state == S_FETCH) begin
      if (w_lastIssue) begin
        r_sramRe <= 1'b0;
      end else begin
        r_sramAddr <= r_sramAddr + ADDR_W'(1);
        r_issueCnt <= r_issueCnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= r_sramRe;
      for (int k = 1; k < RD_LAT; k++) r_vld[k] <= r_vld[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_capCnt <= '0;
    else if (w_accept)  r_capCnt <= '0;
    else if (w_capture) r_capCnt <= r_capCnt + CNT_W'(1);
  end

  // Lowest byte index sits in the word's MSBs; pad bytes past TOT have no register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < TOT; b++) r_wgt[b] <= '0;
    end else if (w_capture) begin
      for (int b = 0; b < TOT; b++) begin
        if (CNT_W'(b / WORD_BYTES) == r_capCnt)
          r_wgt[b] <= sram.sram_rdata[(WORD_BYTES - 1 - (b % WORD_BYTES)) * 8 +: 8];
      end
    end
  end

  always_comb begin
    w_kernel = '0;
    for (int f = 0; f < NUM_FILT; f++) begin
      if (filt_sel == FS_W'(f)) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < CH; c++)
            for (int col = 0; col < K; col++)
              w_kernel[(KB - 1 - ((r * CH + c) * K + col)) * 8 +: 8] =
                r_wgt[((f * CH + c) * K + r) * K + col];
      end
    end
  end

  assign kernel_o       = w_kernel;
  assign sram.sram_re   = r_sramRe;
  assign sram.sram_addr = r_sramAddr;
  assign busy           = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign done           = (r_state == S_DONE);

`ifdef WLOAD_CHECKSUM_EN
  logic [15:0] r_sum;
  logic [15:0] w_wordSum;
  logic        r_chkErr;

  always_comb begin
    w_wordSum = '0;
    for (int j = 0; j < WORD_BYTES; j++) begin
      if ((r_capCnt != CNT_W'(NWORDS - 1)) || (j < LAST_BYTES))
        w_wordSum = w_wordSum + 16'(sram.sram_rdata[(WORD_BYTES - 1 - j) * 8 +: 8]);
    end
  end

  // The final capture lands one edge before done rises, so r_sum is complete here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum    <= '0;
      r_chkErr <= 1'b0;
    end else if (w_accept) begin
      r_sum    <= '0;
      r_chkErr <= 1'b0;
    end else begin
      if (w_capture)  r_sum    <= r_sum + w_wordSum;
      if (w_doneRise) r_chkErr <= (r_sum != cfg_checksum);
    end
  end

  assign chk_err = r_chkErr;
`else
  logic w_unusedChecksum;
  assign w_unusedChecksum = ^cfg_checksum;
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_weight_loader_param.sv
// Bench for weight_loader_param: a default-size instance and an odd-size RD_LAT=3
// instance, each fed by a behavioural SRAM and checked against a byte-level model.
module tb_weight_loader_param;

`ifdef WLOAD_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start0 = 1'b0, start1 = 1'b0;
  logic [15:0]   base0 = '0, base1 = '0, cks0 = '0, cks1 = '0;
  logic [3:0]    filt0 = '0;
  logic [0:0]    filt1 = '0;
  logic [287:0]  kernel0;
  logic [215:0]  kernel1;
  logic          busy0, done0, err0, busy1, done1, err1;

  logic [15:0]   mem0 [144];
  logic [15:0]   mem1 [14];
  logic [15:0]   mBase [2];
  int            ep [2];
  int            rdCnt [2];
  int            rdBad [2];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic [15:0]   rd0;
  logic [15:0]   p1 [3];

  weight_loader_param_if #(.WORD_BYTES(2), .ADDR_W(16)) if0 ();
  weight_loader_param_if #(.WORD_BYTES(2), .ADDR_W(16)) if1 ();

  weight_loader_param u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cfg_base_addr(base0), .cfg_checksum(cks0),
    .sram(if0), .filt_sel(filt0), .kernel_o(kernel0), .busy(busy0), .done(done0), .chk_err(err0)
  );

  weight_loader_param #(.WORD_BYTES(2), .ADDR_W(16), .K(3), .CH(3), .NUM_FILT(1), .RD_LAT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cfg_base_addr(base1), .cfg_checksum(cks1),
    .sram(if1), .filt_sel(filt1), .kernel_o(kernel1), .busy(busy1), .done(done1), .chk_err(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] memRd(input int which, input logic [15:0] a);
    logic [15:0] idx;
    idx = a - mBase[which];
    if (which == 0) return (idx < 16'd144) ? mem0[idx] : 16'hBAD0;
    return (idx < 16'd14) ? mem1[idx] : 16'hBAD0;
  endfunction

  // Behavioural SRAMs: one-stage and three-stage read pipelines.
  always @(posedge clk) begin
    rd0   <= if0.sram_re ? memRd(0, if0.sram_addr) : 16'hDEAD;
    p1[0] <= if1.sram_re ? memRd(1, if1.sram_addr) : 16'hDEAD;
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign if0.sram_rdata = rd0;
  assign if1.sram_rdata = p1[2];

  // Read monitor: read n must carry base+n and be issued exactly n edges after E0.
  always @(posedge clk) begin
    if (if0.sram_re) begin
      if (if0.sram_addr !== 16'(mBase[0] + rdCnt[0]) || (cyc - ep[0] - 1) != rdCnt[0])
        rdBad[0] <= rdBad[0] + 1;
      rdCnt[0] <= rdCnt[0] + 1;
    end
    if (if1.sram_re) begin
      if (if1.sram_addr !== 16'(mBase[1] + rdCnt[1]) || (cyc - ep[1] - 1) != rdCnt[1])
        rdBad[1] <= rdBad[1] + 1;
      rdCnt[1] <= rdCnt[1] + 1;
    end
  end

  function automatic logic [7:0] expByte(input int which, input int b);
    logic [15:0] w;
    w = (which == 0) ? mem0[b / 2] : mem1[b / 2];
    return (b % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [287:0] expKernel(input int which, input int f);
    logic [287:0] k;
    int nf, ch;
    nf = (which == 0) ? 8 : 1;
    ch = (which == 0) ? 4 : 3;
    k = '0;
    if (f >= nf) return k;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < ch; c++)
        for (int col = 0; col < 3; col++)
          k = {k[279:0], expByte(which, ((f * ch + c) * 3 + r) * 3 + col)};
    return k;
  endfunction

  function automatic logic [15:0] expSum(input int which);
    logic [15:0] s;
    s = '0;
    for (int b = 0; b < ((which == 0) ? 288 : 27); b++) s = s + 16'(expByte(which, b));
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [287:0] observed, input logic [287:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int which, input logic [15:0] base, input logic [15:0] cks);
    @(negedge clk);
    mBase[which] = base;
    rdCnt[which] = 0;
    rdBad[which] = 0;
    if (which == 0) begin base0 = base; cks0 = cks; start0 = 1'b1; end
    else            begin base1 = base; cks1 = cks; start1 = 1'b1; end
    @(posedge clk);
    ep[which] = cyc;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    base0 = 16'($urandom);
    base1 = 16'($urandom);
  endtask

  task automatic waitDone(input int which, input int pulseAt, output int doneEdge, output int busyBad);
    doneEdge = -1;
    busyBad = 0;
    for (int n = 0; n < 400; n++) begin
      if ((which == 0) ? done0 : done1) begin
        doneEdge = cyc - ep[which] - 1;
        break;
      end
      if (!((which == 0) ? busy0 : busy1)) busyBad++;
      if (which == 0) start0 = (cyc - ep[0] == pulseAt);
      @(negedge clk);
    end
    start0 = 1'b0;
  endtask

  task automatic checkKernels0(input string tag);
    for (int f = 0; f < 9; f++) begin
      filt0 = 4'(f);
      #1;
      checkOutput($sformatf("%s_kern_f%0d", tag, f), kernel0, expKernel(0, f));
    end
    filt0 = 4'd15;
    #1;
    checkOutput({tag, "_kern_f15"}, kernel0, '0);
    filt0 = 4'd0;
  endtask

  initial begin
    int de, bb, rc;
    logic [15:0] cs, lw;
    logic [95:0] row0Exp;

    repeat (3) @(negedge clk);
    checkOutput("rst_re0", if0.sram_re, 1'b0);
    checkOutput("rst_addr0", if0.sram_addr, 16'h0);
    checkOutput("rst_busy0", busy0, 1'b0);
    checkOutput("rst_done0", done0, 1'b0);
    checkOutput("rst_err0", err0, 1'b0);
    checkOutput("rst_kern0", kernel0, '0);
    checkOutput("rst_done1", done1, 1'b0);
    checkOutput("rst_re1", if1.sram_re, 1'b0);
    rst_n = 1'b1;

    // Directed pattern load: word i = {2i, 2i+1} at base 0x0100.
    for (int i = 0; i < 144; i++) mem0[i] = {8'(2 * i), 8'(2 * i + 1)};
    applyStimulus(0, 16'h0100, expSum(0));
    waitDone(0, -1, de, bb);
    checkOutput("A_doneEdge", 288'(de), 288'(146));
    checkOutput("A_busyHeld", 288'(bb), 288'(0));
    checkOutput("A_busyLow", busy0, 1'b0);
    checkOutput("A_reads", 288'(rdCnt[0]), 288'(144));
    checkOutput("A_readSeq", 288'(rdBad[0]), 288'(0));
    checkOutput("A_chkErr", err0, 1'b0);
    row0Exp = 96'h000102090A0B1213141B1C1D;
    filt0 = 4'd0;
    #1;
    checkOutput("A_row0", kernel0[287:192], row0Exp);
    checkKernels0("A");

    // Random reload from DONE, wrapping addresses, start pulse at E50, bad checksum.
    for (int i = 0; i < 144; i++) mem0[i] = 16'($urandom);
    cs = expSum(0) + 16'd1;
    applyStimulus(0, 16'hFFC0, cs);
    checkOutput("B_doneDrop", done0, 1'b0);
    waitDone(0, 50, de, bb);
    checkOutput("B_doneEdge", 288'(de), 288'(146));
    checkOutput("B_busyHeld", 288'(bb), 288'(0));
    checkOutput("B_reads", 288'(rdCnt[0]), 288'(144));
    checkOutput("B_readSeq", 288'(rdBad[0]), 288'(0));
    checkOutput("B_chkErr", err0, CHK_EN);
    checkKernels0("B");

    // Reset in the middle of a load, then a clean reload.
    for (int i = 0; i < 144; i++) mem0[i] = 16'($urandom);
    applyStimulus(0, 16'($urandom), expSum(0));
    repeat (69) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("C_rstRe", if0.sram_re, 1'b0);
    checkOutput("C_rstBusy", busy0, 1'b0);
    checkOutput("C_rstDone", done0, 1'b0);
    checkOutput("C_rstKern", kernel0, '0);
    rc = rdCnt[0];
    repeat (4) @(negedge clk);
    checkOutput("C_noReads", 288'(rdCnt[0]), 288'(rc));
    rst_n = 1'b1;
    for (int i = 0; i < 144; i++) mem0[i] = 16'($urandom);
    applyStimulus(0, 16'($urandom), expSum(0));
    waitDone(0, -1, de, bb);
    checkOutput("C_doneEdge", 288'(de), 288'(146));
    checkOutput("C_reads", 288'(rdCnt[0]), 288'(144));
    checkOutput("C_readSeq", 288'(rdBad[0]), 288'(0));
    checkOutput("C_chkErr", err0, 1'b0);
    checkKernels0("C");

    // Odd-size instance: 27 bytes in 14 words, RD_LAT=3, wrapping base.
    for (int i = 0; i < 14; i++) mem1[i] = 16'($urandom);
    applyStimulus(1, 16'hFFF8, expSum(1));
    waitDone(1, -1, de, bb);
    checkOutput("D_doneEdge", 288'(de), 288'(18));
    checkOutput("D_busyHeld", 288'(bb), 288'(0));
    checkOutput("D_reads", 288'(rdCnt[1]), 288'(14));
    checkOutput("D_readSeq", 288'(rdBad[1]), 288'(0));
    checkOutput("D_chkErr", err1, 1'b0);
    filt1 = 1'b0;
    #1;
    checkOutput("D_kern_f0", kernel1, expKernel(1, 0));
    lw = mem1[13];
    checkOutput("D_byte26", kernel1[7:0], lw[15:8]);
    filt1 = 1'b1;
    #1;
    checkOutput("D_kern_f1", kernel1, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_loader_param.md
# weight_loader_param

Parametrised weight loader for the conv PE array. It streams one layer's kernel weights from weight SRAM into local registers after a start pulse. The layer size (filters × channels × K×K) and the SRAM word width are parameters. It then presents the full kernel of a selected filter, row-packed, to the PE columns. One instance is used per conv layer, replacing the fixed two-layer loader.

## Interface
- `WORD_BYTES`, 2, SRAM word width in bytes (1..8); SRAM data width is `WORD_BYTES*8`.
- `ADDR_W`, 16, SRAM address width.
- `K`, 3, kernel side (K×K taps).
- `CH`, 4, input channels per filter.
- `NUM_FILT`, 8, filters in the layer.
- `RD_LAT`, 1, SRAM read latency in cycles (1..4).
- `clk`  in  1  clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  load request pulse; sampled only in IDLE or DONE.
- `cfg_base_addr`  in  ADDR_W  first SRAM word address; latched on accepted start.
- `cfg_checksum`  in  16  expected byte sum (used only with `WLOAD_CHECKSUM_EN`).
- `sram_re`  out  1  read enable.
- `sram_addr`  out  ADDR_W  read address.
- `sram_rdata`  in  WORD_BYTES*8  read data, valid RD_LAT cycles after `sram_re`.
- `filt_sel`  in  clog2(NUM_FILT)+1  filter whose kernel is driven on `kernel_o`.
- `kernel_o`  out  K*K*CH*8  selected filter's weights, packing below.
- `busy`  out  1  load in progress.
- `done`  out  1  level; all weights valid.
- `chk_err`  out  1  checksum mismatch, valid while `done`.

## Operation
- `TOT = NUM_FILT*CH*K*K` bytes.
- `NWORDS = ceil(TOT/WORD_BYTES)`.
- Storage byte index: `b = ((f*CH + c)*K + r)*K + col`.
- SRAM word i holds bytes `b = i*WORD_BYTES ..`, with the lowest b in the MSBs of the word.
- In the last word, bytes with b ≥ TOT are discarded.
- States and transitions:
  - IDLE: on `start` → FETCH. Latch `cfg_base_addr`, clear the issue/capture counters and `done`.
  - FETCH: issue word i = 0..NWORDS-1 one per cycle with `sram_re`=1 and `sram_addr = base + i` (mod 2^ADDR_W). After the last issue → DRAIN.
  - DRAIN: `sram_re`=0; wait for the outstanding captures.
  - DONE: `done`=1. A new `start` reloads (→ FETCH; `done` drops the next cycle).
- Capture uses a RD_LAT-deep valid shift register aligned to `sram_re`. Each valid cycle writes WORD_BYTES bytes at the capture counter position.
- `start` in FETCH or DRAIN is ignored.
- `kernel_o` is combinational from the weight registers and `filt_sel`:
  - Row r=0 occupies the most significant segment.
  - Each row is the concatenation over c=0..CH-1 (c=0 most significant) of cols 0..K-1 (col 0 most significant).
  - `filt_sel` ≥ NUM_FILT drives all zeros.
- Weight registers keep old contents during a reload until overwritten.
- `kernel_o` is defined only while `done`=1.

## Timing
- Reset values: state IDLE, `sram_re`=0, `sram_addr`=0, `busy`=0, `done`=0, `chk_err`=0, all weight bytes 0, counters 0.
- Edges are numbered from E0, the edge at which `start` is accepted.
- Word i is issued in the cycle after E(i). It is captured at E(i+1+RD_LAT).
- `done` rises at E(NWORDS+RD_LAT+1), which is the edge after the final capture.
- `busy`=1 from E0+ through the edge at which `done` rises (exclusive).
- Reset mid-load: immediate return to reset values; no further SRAM reads.
- Sustained throughput is one SRAM word per cycle with no bubbles.

## Configuration
- `WLOAD_CHECKSUM_EN` defined:
  - A 16-bit accumulator (mod 2^16) sums every stored byte; discarded pad bytes are excluded.
  - At the edge `done` rises, `chk_err` is set to (sum ≠ `cfg_checksum`).
  - Accepting `start` clears the accumulator and `chk_err`.
- Not defined: no accumulator; `chk_err` is tied to 0 and `cfg_checksum` is unused.
- The ports are identical in both builds.

## Test plan
- Load with defaults, base 0x0100, SRAM word i = {2i, 2i+1}, RD_LAT=1:
  - 144 reads at addresses 0x0100..0x018F on consecutive cycles.
  - `done` rises at E146.
  - `filt_sel`=0 gives `kernel_o` bytes 0x00..0x23, row 0 = {00,01,02,09,0A,0B,12,13,14,1B,1C,1D}.
- Odd size, K=3, CH=3, NUM_FILT=1, WORD_BYTES=2:
  - 14 reads.
  - The low byte of word 13 is discarded; `kernel_o` byte 26 equals the high byte of word 13.
- RD_LAT=3, otherwise default: addresses unchanged; `done` rises at E148; same `kernel_o` as the first test.
- `start` pulsed at E50 during FETCH: no restart, no extra reads, `done` still at E146.
- Reset pulse at E70:
  - `sram_re`=0 and `busy`=0 immediately; all `kernel_o` = 0.
  - A new start then completes normally.
- `WLOAD_CHECKSUM_EN`:
  - Correct `cfg_checksum` gives `chk_err`=0.
  - `cfg_checksum` off by one gives `chk_err`=1 at the edge where `done` rises.
  - `filt_sel`=8 gives `kernel_o`=0.
